// File: rtl/parking_meter_buttons_pkg.sv
// Shared definitions for the parking meter push-button front-end:
// channel indices, arbiter state encoding and the issue-priority picker.
package parking_meter_pkg;

    localparam int NUM_BTN = 6;

    localparam int CH_ADD1 = 0;
    localparam int CH_ADD2 = 1;
    localparam int CH_ADD3 = 2;
    localparam int CH_ADD4 = 3;
    localparam int CH_RST1 = 4;
    localparam int CH_RST2 = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        GAP   = 2'b10
    } arb_state_t;

    // One-hot grant of the most urgent pending command: presets first, then adds.
    function automatic logic [NUM_BTN-1:0] pick_first(input logic [NUM_BTN-1:0] pend);
        logic [NUM_BTN-1:0] grant;
        grant = '0;
        if (pend[CH_RST1])      grant[CH_RST1] = 1'b1;
        else if (pend[CH_RST2]) grant[CH_RST2] = 1'b1;
        else if (pend[CH_ADD1]) grant[CH_ADD1] = 1'b1;
        else if (pend[CH_ADD2]) grant[CH_ADD2] = 1'b1;
        else if (pend[CH_ADD3]) grant[CH_ADD3] = 1'b1;
        else if (pend[CH_ADD4]) grant[CH_ADD4] = 1'b1;
        return grant;
    endfunction

endpackage

// File: rtl/parking_meter_buttons_if.sv
// Button-side bundle: raw button levels in, command pulses and debounced levels out.
// The slave modport is the front-end itself; master is whoever presses buttons.
interface parking_meter_buttons_if;
    import parking_meter_pkg::*;

    logic [NUM_BTN-1:0] btn_in;
    logic               add1;
    logic               add2;
    logic               add3;
    logic               add4;
    logic               rst1;
    logic               rst2;
    logic [NUM_BTN-1:0] btn_level;

    modport slave (
        input  btn_in,
        output add1, add2, add3, add4, rst1, rst2, btn_level
    );

    modport master (
        output btn_in,
        input  add1, add2, add3, add4, rst1, rst2, btn_level
    );

endinterface

// File: rtl/parking_meter_buttons_debounce.sv
// One button channel: 2-flop synchronizer, consecutive-cycle debounce counter,
// accepted level and a one-cycle strobe when the accepted level rises.
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= 2'b00;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            rise <= 1'b0;
            // Any cycle agreeing with the accepted level restarts the count.
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
                rise  <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_meter_buttons.sv
// Parking meter button front-end: six debounced channels feeding a pending/arbiter
// stage that issues one registered command pulse at a time. AUTO_REPEAT_EN adds hold-to-repeat.
//
// state | meaning
// IDLE  | nothing pending, all pulses low
// ISSUE | exactly one command pulse is high this cycle
// GAP   | all pulses low for one cycle; chains straight to ISSUE if work is pending
module parking_meter_buttons
    import parking_meter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 20000000
) (
    input  logic                    clk,
    input  logic                    rst,
    parking_meter_buttons_if.slave  bus
);

    if (DEBOUNCE_CYCLES < 2 || (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_debounce
        $error("parking_meter_buttons: DEBOUNCE_CYCLES must be >= 2 and below 2**CNT_W");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
        $error("parking_meter_buttons: REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] rep_set;
    logic [NUM_BTN-1:0] pending;
    logic [NUM_BTN-1:0] pending_nxt;
    logic [NUM_BTN-1:0] clr;
    logic [NUM_BTN-1:0] pulse;
    logic [NUM_BTN-1:0] pulse_nxt;
    arb_state_t         state;
    arb_state_t         state_nxt;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .din   (bus.btn_in[i]),
            .level (level[i]),
            .rise  (rise[i])
        );
    end

`ifdef AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt;
    logic             trk_vld;
    logic [1:0]       trk_idx;
    logic [1:0]       held_idx;
    logic             held_any;

    // Repeat timer follows the lowest-index add button currently held.
    always_comb begin
        held_any = |level[CH_ADD4:CH_ADD1];
        held_idx = 2'd0;
        for (int i = CH_ADD4; i >= CH_ADD1; i--) begin
            if (level[i]) held_idx = 2'(i);
        end
    end

    always_comb begin
        rep_set = '0;
        if (trk_vld && held_any && trk_idx == held_idx && rep_cnt == '0)
            rep_set[trk_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trk_vld <= 1'b0;
            trk_idx <= 2'd0;
            rep_cnt <= '0;
        end else if (!held_any) begin
            trk_vld <= 1'b0;
        end else if (!trk_vld || trk_idx != held_idx) begin
            trk_vld <= 1'b1;
            trk_idx <= held_idx;
            rep_cnt <= REP_W'(REPEAT_DELAY - 1);
        end else if (rep_cnt == '0) begin
            rep_cnt <= REP_W'(REPEAT_RATE - 1);
        end else begin
            rep_cnt <= rep_cnt - 1'b1;
        end
    end
`else
    assign rep_set = '0;
`endif

    // A press landing on an already-pending channel simply merges into it.
    assign pending_nxt = (pending & ~clr) | rise | rep_set;

    always_comb begin
        state_nxt = state;
        pulse_nxt = '0;
        clr       = '0;
        case (state)
            IDLE, GAP: begin
                if (|pending) begin
                    state_nxt = ISSUE;
                    pulse_nxt = pick_first(pending);
                    clr       = pulse_nxt;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ISSUE:   state_nxt = GAP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pulse   <= '0;
            pending <= '0;
        end else begin
            state   <= state_nxt;
            pulse   <= pulse_nxt;
            pending <= pending_nxt;
        end
    end

    assign bus.add1      = pulse[CH_ADD1];
    assign bus.add2      = pulse[CH_ADD2];
    assign bus.add3      = pulse[CH_ADD3];
    assign bus.add4      = pulse[CH_ADD4];
    assign bus.rst1      = pulse[CH_RST1];
    assign bus.rst2      = pulse[CH_RST2];
    assign bus.btn_level = level;

endmodule
